// File: rtl/cordic_ctrl_pkg.sv
// cordic_ctrl_pkg: shared definitions for the iterative CORDIC sequencer.
//   ctrl_state_t  : sequencer state encoding (IDLE=0, QUAD=1, ISSUE=2, WAIT=3, DONE=4)
//   ITER_MAX      : largest supported iteration count
//   IDX_W         : width of the stage iteration index
//   ang_half_pi() : binary-angle value of pi/2 for a given datapath width
package cordic_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    localparam int ITER_MAX = 32;
    localparam int IDX_W    = 5;

    // Angles are binary: 2^(dsize-1) corresponds to pi, so pi/2 is 2^(dsize-2).
    function automatic int ang_half_pi(input int dsize);
        return 1 << (dsize - 2);
    endfunction

endpackage

// File: rtl/cordic_quad_pre.sv
// cordic_quad_pre: combinational quadrant pre-rotation by +/- pi/2.
// Folds an angle outside (-pi/2, pi/2) back into range so the iterative
// rotation can converge over the full +/- pi circle.
//   x_i, y_i, z_i : vector and angle before folding
//   x_o, y_o, z_o : vector and angle after folding
// Only instantiated when CORDIC_ITER_QUAD_EN is defined.
module cordic_quad_pre
    import cordic_ctrl_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic signed [DSIZE-1:0] x_i,
    input  logic signed [DSIZE-1:0] y_i,
    input  logic signed [DSIZE-1:0] z_i,
    output logic signed [DSIZE-1:0] x_o,
    output logic signed [DSIZE-1:0] y_o,
    output logic signed [DSIZE-1:0] z_o
);

    localparam int                      HP_INT      = ang_half_pi(DSIZE);
    localparam logic signed [DSIZE-1:0] HALF_PI     = HP_INT[DSIZE-1:0];
    localparam logic signed [DSIZE-1:0] NEG_HALF_PI = -HALF_PI;
    localparam logic signed [DSIZE-1:0] MOST_NEG    = {1'b1, {(DSIZE-1){1'b0}}};
    localparam logic signed [DSIZE-1:0] MOST_POS    = {1'b0, {(DSIZE-1){1'b1}}};

    // The most negative value has no positive counterpart; clamp it.
    function automatic logic signed [DSIZE-1:0] neg_sat(input logic signed [DSIZE-1:0] v);
        return (v == MOST_NEG) ? MOST_POS : -v;
    endfunction

    always_comb begin
        x_o = x_i;
        y_o = y_i;
        z_o = z_i;
        if (z_i >= HALF_PI) begin
            x_o = neg_sat(y_i);
            y_o = x_i;
            z_o = z_i - HALF_PI;
        end else if (z_i < NEG_HALF_PI) begin
            x_o = y_i;
            y_o = neg_sat(x_i);
            z_o = z_i + HALF_PI;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative sequencer for one shared CORDIC rotation stage.
// Accepts one (X, Y, Z) job, drives the stage ITER times with I = 0..ITER-1,
// feeding each stage result back as the next operand, then presents the
// final vector/angle until the consumer takes it.
//
// Ports
//   clock, rst                : clock and synchronous active-high reset
//   in_valid/in_ready         : job handshake; x_in, y_in, z_in job operands
//   out_valid/out_ready       : result handshake; x_out, y_out, z_out results
//   busy                      : high whenever not IDLE
//   stg_x/y/z, stg_i, stg_dir : operands, iteration index, direction to stage
//   stg_xr/yr/zr              : stage results, valid STAGE_LAT cycles after issue
//
// Build option: define CORDIC_ITER_QUAD_EN to add the quadrant pre-rotation
// state (rotation mode only). Without it convergence is limited to ~+/-99.9 deg.
//
// state | meaning
// IDLE  | waiting for a job; in_ready high, stage operands zero
// QUAD  | one-cycle quadrant fold of the working angle (optional)
// ISSUE | stage operands presented for iteration k
// WAIT  | operands held for the stage latency, result captured on the last cycle
// DONE  | result loaded then held with out_valid until out_ready
module cordic_iter_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int    DSIZE     = 16,
    parameter string ROTTMODE  = "ROTT",
    parameter int    ITER      = 16,
    parameter int    STAGE_LAT = 1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DSIZE-1:0] x_in,
    input  logic signed [DSIZE-1:0] y_in,
    input  logic signed [DSIZE-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DSIZE-1:0] x_out,
    output logic signed [DSIZE-1:0] y_out,
    output logic signed [DSIZE-1:0] z_out,
    output logic                    busy,
    output logic signed [DSIZE-1:0] stg_x,
    output logic signed [DSIZE-1:0] stg_y,
    output logic signed [DSIZE-1:0] stg_z,
    output logic [IDX_W-1:0]        stg_i,
    output logic                    stg_dir,
    input  logic signed [DSIZE-1:0] stg_xr,
    input  logic signed [DSIZE-1:0] stg_yr,
    input  logic signed [DSIZE-1:0] stg_zr
);

    localparam bit               IS_VEC    = (ROTTMODE == "VECTOR");
    localparam int               K_LAST_I  = ITER - 1;
    localparam logic [IDX_W-1:0] K_LAST    = K_LAST_I[IDX_W-1:0];
    localparam int               WCW       = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam int               WLOAD_I   = STAGE_LAT - 1;
    localparam logic [WCW-1:0]   WAIT_LOAD = WLOAD_I[WCW-1:0];

    ctrl_state_t             state_q, state_d;
    logic signed [DSIZE-1:0] wx_q, wx_d, wy_q, wy_d, wz_q, wz_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic signed [DSIZE-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic signed [DSIZE-1:0] stg_x_q, stg_x_d, stg_y_q, stg_y_d, stg_z_q, stg_z_d;
    logic [IDX_W-1:0]        stg_i_q, stg_i_d;
    logic                    stg_dir_q, stg_dir_d;

`ifdef CORDIC_ITER_QUAD_EN
    logic signed [DSIZE-1:0] qx, qy, qz;

    cordic_quad_pre #(
        .DSIZE (DSIZE)
    ) u_quad (
        .x_i (wx_q),
        .y_i (wy_q),
        .z_i (wz_q),
        .x_o (qx),
        .y_o (qy),
        .z_o (qz)
    );
`endif

    // Rotation mode steers the residual angle to zero, vectoring steers Y to zero.
    function automatic logic pick_dir(input logic signed [DSIZE-1:0] y,
                                      input logic signed [DSIZE-1:0] z);
        return IS_VEC ? y[DSIZE-1] : ~z[DSIZE-1];
    endfunction

    always_comb begin
        state_d     = state_q;
        wx_d        = wx_q;
        wy_d        = wy_q;
        wz_d        = wz_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        z_out_d     = z_out_q;
        stg_x_d     = stg_x_q;
        stg_y_d     = stg_y_q;
        stg_z_d     = stg_z_q;
        stg_i_d     = stg_i_q;
        stg_dir_d   = stg_dir_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    wx_d = x_in;
                    wy_d = y_in;
                    wz_d = z_in;
                    k_d  = '0;
`ifdef CORDIC_ITER_QUAD_EN
                    // The fold is meaningless in vectoring mode, so skip it there.
                    state_d = IS_VEC ? ST_ISSUE : ST_QUAD;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
`ifdef CORDIC_ITER_QUAD_EN
            ST_QUAD: begin
                wx_d    = qx;
                wy_d    = qy;
                wz_d    = qz;
                state_d = ST_ISSUE;
            end
`endif
            ST_ISSUE: begin
                wcnt_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    wx_d = stg_xr;
                    wy_d = stg_yr;
                    wz_d = stg_zr;
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + IDX_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            ST_DONE: begin
                // First DONE cycle loads the result; out_valid follows one cycle later.
                if (!out_valid_q) begin
                    x_out_d     = wx_q;
                    y_out_d     = wy_q;
                    z_out_d     = wz_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stage operands are registered so they are stable for the whole ISSUE/WAIT window.
        if (state_d == ST_ISSUE) begin
            stg_x_d   = wx_d;
            stg_y_d   = wy_d;
            stg_z_d   = wz_d;
            stg_i_d   = k_d;
            stg_dir_d = pick_dir(wy_d, wz_d);
        end else if (state_d == ST_IDLE) begin
            stg_x_d   = '0;
            stg_y_d   = '0;
            stg_z_d   = '0;
            stg_i_d   = '0;
            stg_dir_d = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wx_q        <= '0;
            wy_q        <= '0;
            wz_q        <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            stg_x_q     <= '0;
            stg_y_q     <= '0;
            stg_z_q     <= '0;
            stg_i_q     <= '0;
            stg_dir_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            wz_q        <= wz_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            z_out_q     <= z_out_d;
            stg_x_q     <= stg_x_d;
            stg_y_q     <= stg_y_d;
            stg_z_q     <= stg_z_d;
            stg_i_q     <= stg_i_d;
            stg_dir_q   <= stg_dir_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
    assign stg_x     = stg_x_q;
    assign stg_y     = stg_y_q;
    assign stg_z     = stg_z_q;
    assign stg_i     = stg_i_q;
    assign stg_dir   = stg_dir_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl. Three instances: ROTT/ITER=16/LAT=1,
// VECTOR/ITER=16/LAT=1 and ROTT/ITER=4/LAT=3, each with a behavioural
// stage model. Results are compared against a job-level reference model.
module tb_cordic_iter_ctrl;

`ifdef CORDIC_ITER_QUAD_EN
    localparam int QUAD = 1;
`else
    localparam int QUAD = 0;
`endif

    localparam int  ITERS [3] = '{16, 16, 4};
    localparam int  LATS  [3] = '{1, 1, 3};
    localparam bit  VECS  [3] = '{1'b0, 1'b1, 1'b0};
    localparam real PI        = 3.14159265358979;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vec3_t;

    typedef struct {
        int u;
        int x, y, z;
        int ex, ey, ez;
        int tol;
        int lat;
    } tvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t0 [3];
    int   checks = 0;
    int   failures = 0;

    logic               iv [3], ir [3], ov [3], ordy [3], bsy [3], sd [3];
    logic signed [15:0] xi [3], yi [3], zi [3];
    logic signed [15:0] xo [3], yo [3], zo [3];
    logic signed [15:0] sx [3], sy [3], sz [3];
    logic signed [15:0] sxr [3], syr [3], szr [3];
    logic [4:0]         si [3];

    vec3_t snext [3];
    vec3_t pipe  [3][3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_iter_ctrl #(.DSIZE(16), .ROTTMODE("ROTT"), .ITER(16), .STAGE_LAT(1)) u_rott (
        .clock(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .x_in(xi[0]), .y_in(yi[0]), .z_in(zi[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .x_out(xo[0]), .y_out(yo[0]), .z_out(zo[0]),
        .busy(bsy[0]), .stg_x(sx[0]), .stg_y(sy[0]), .stg_z(sz[0]), .stg_i(si[0]), .stg_dir(sd[0]),
        .stg_xr(sxr[0]), .stg_yr(syr[0]), .stg_zr(szr[0]));

    cordic_iter_ctrl #(.DSIZE(16), .ROTTMODE("VECTOR"), .ITER(16), .STAGE_LAT(1)) u_vec (
        .clock(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .x_in(xi[1]), .y_in(yi[1]), .z_in(zi[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .x_out(xo[1]), .y_out(yo[1]), .z_out(zo[1]),
        .busy(bsy[1]), .stg_x(sx[1]), .stg_y(sy[1]), .stg_z(sz[1]), .stg_i(si[1]), .stg_dir(sd[1]),
        .stg_xr(sxr[1]), .stg_yr(syr[1]), .stg_zr(szr[1]));

    cordic_iter_ctrl #(.DSIZE(16), .ROTTMODE("ROTT"), .ITER(4), .STAGE_LAT(3)) u_lat3 (
        .clock(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]), .x_in(xi[2]), .y_in(yi[2]), .z_in(zi[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .x_out(xo[2]), .y_out(yo[2]), .z_out(zo[2]),
        .busy(bsy[2]), .stg_x(sx[2]), .stg_y(sy[2]), .stg_z(sz[2]), .stg_i(si[2]), .stg_dir(sd[2]),
        .stg_xr(sxr[2]), .stg_yr(syr[2]), .stg_zr(szr[2]));

    // arctan(2^-i) in binary-angle units (2^15 = pi)
    function automatic int atan_lsb(input int i);
        return $rtoi($atan(1.0 / (2.0 ** i)) * 32768.0 / PI + 0.5);
    endfunction

    // One micro-rotation: dir=1 rotates counter-clockwise and subtracts the angle.
    function automatic vec3_t stage_fn(input vec3_t v, input int i, input logic dir);
        logic signed [15:0] x, y, z, xs, ys, a;
        vec3_t r;
        x  = v.x;
        y  = v.y;
        z  = v.z;
        xs = x >>> i;
        ys = y >>> i;
        a  = 16'(atan_lsb(i));
        if (dir) begin
            r.x = x - ys;
            r.y = y + xs;
            r.z = z - a;
        end else begin
            r.x = x + ys;
            r.y = y - xs;
            r.z = z + a;
        end
        return r;
    endfunction

    // Whole-job reference: optional quadrant fold, then ITER micro-rotations.
    function automatic vec3_t ref_job(input vec3_t v, input int iter, input bit vec);
        logic signed [15:0] x, y, z;
        int    zv, t;
        vec3_t w;
        x = v.x;
        y = v.y;
        z = v.z;
        if (QUAD == 1 && !vec) begin
            zv = int'(z);
            if (zv >= 16384) begin
                t = -int'(y);
                if (t > 32767) t = 32767;
                y = x;
                x = 16'(t);
                z = 16'(zv - 16384);
            end else if (zv < -16384) begin
                t = -int'(x);
                if (t > 32767) t = 32767;
                x = y;
                y = 16'(t);
                z = 16'(zv + 16384);
            end
        end
        for (int k = 0; k < iter; k++) begin
            w = stage_fn({x, y, z}, k, vec ? (y < 0) : (z >= 0));
            x = w.x;
            y = w.y;
            z = w.z;
        end
        return {x, y, z};
    endfunction

    always_comb begin
        for (int u = 0; u < 3; u++)
            snext[u] = stage_fn({sx[u], sy[u], sz[u]}, int'(si[u]), sd[u]);
    end

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            pipe[u][0] <= snext[u];
            pipe[u][1] <= pipe[u][0];
            pipe[u][2] <= pipe[u][1];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_stage
        assign sxr[g] = pipe[g][LATS[g]-1].x;
        assign syr[g] = pipe[g][LATS[g]-1].y;
        assign szr[g] = pipe[g][LATS[g]-1].z;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    // Present a job; returns at the negedge after the accepting edge.
    task automatic start_job(input int u, input vec3_t v);
        @(negedge clk);
        chk("in_ready_before_job", int'(ir[u]), 1);
        iv[u] = 1'b1;
        xi[u] = v.x;
        yi[u] = v.y;
        zi[u] = v.z;
        @(posedge clk);
        @(negedge clk);
        t0[u] = cyc;
        iv[u] = 1'b0;
    endtask

    task automatic wait_valid(input int u, output int lat);
        int n = 0;
        while (!ov[u] && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = cyc - t0[u];
        if (!ov[u]) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: unit %0d got no out_valid within %0d cycles", u, n);
        end
    endtask

    task automatic release_out(input int u);
        ordy[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[u] = 1'b0;
        chk("out_valid_after_take", int'(ov[u]), 0);
        chk("in_ready_after_take", int'(ir[u]), 1);
        chk("stg_x_zero_in_idle", int'(sx[u]), 0);
    endtask

    task automatic check_exact(input int u, input vec3_t exp);
        chk("x_out_model", int'(xo[u]), int'($signed(exp.x)));
        chk("y_out_model", int'(yo[u]), int'($signed(exp.y)));
        chk("z_out_model", int'(zo[u]), int'($signed(exp.z)));
    endtask

    function automatic int exp_lat(input int u);
        return 1 + ITERS[u] * (LATS[u] + 1) + ((QUAD == 1 && !VECS[u]) ? 1 : 0);
    endfunction

    tvec_t tab[$];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int    lat, n, hold, u;
        vec3_t v, e;
        logic signed [15:0] hx, hy, hz;

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; xi[k] = '0; yi[k] = '0; zi[k] = '0;
        end

        // Reset state, observed while reset is still asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", int'(ir[k]), 1);
            chk("rst_out_valid", int'(ov[k]), 0);
            chk("rst_busy", int'(bsy[k]), 0);
            chk("rst_x_out", int'(xo[k]), 0);
            chk("rst_stg_x", int'(sx[k]), 0);
            chk("rst_stg_i", int'(si[k]), 0);
        end
        rst = 1'b0;

        // Directed vectors with known CORDIC results
        tab.push_back('{0, 'h2000, 0, 0, 'h34B4, 0, 0, 4, 33 + QUAD});
        tab.push_back('{0, 'h2000, 0, 'h2000, 'h2543, 'h2543, 0, 8, 33 + QUAD});
        tab.push_back('{0, 'h1000, 0, -'h2000, 'h12A2, -'h12A2, 0, 8, 33 + QUAD});
        tab.push_back('{1, 'h1000, 'h1000, 0, 'h2543, 0, 'h2000, 4, 33});
        tab.push_back('{1, 'h2000, 0, 0, 'h34B4, 0, 0, 8, 33});
        tab.push_back('{1, 'h1000, -'h1000, 0, 'h2543, 0, -'h2000, 8, 33});
`ifdef CORDIC_ITER_QUAD_EN
        tab.push_back('{0, 'h2000, 0, 'h6000, -'h2543, 'h2543, 0, 6, 34});
`endif
        foreach (tab[t]) begin
            v = {16'(tab[t].x), 16'(tab[t].y), 16'(tab[t].z)};
            start_job(tab[t].u, v);
            chk("busy_during_job", int'(bsy[tab[t].u]), 1);
            wait_valid(tab[t].u, lat);
            chk("tab_latency", lat, tab[t].lat);
            chk_tol("tab_x_out", int'(xo[tab[t].u]), tab[t].ex, tab[t].tol);
            chk_tol("tab_y_out", int'(yo[tab[t].u]), tab[t].ey, tab[t].tol);
            chk_tol("tab_z_out", int'(zo[tab[t].u]), tab[t].ez, tab[t].tol);
            release_out(tab[t].u);
        end

        // STAGE_LAT=3, ITER=4: each index held for four cycles
        v = {16'h1800, 16'h0400, 16'h1000};
        start_job(2, v);
        for (int c = 0; c < 16 + QUAD; c++) begin
            if (c >= QUAD) chk("lat3_stg_i", int'(si[2]), (c - QUAD) / 4);
            @(posedge clk);
            @(negedge clk);
        end
        wait_valid(2, lat);
        chk("lat3_latency", lat, 17 + QUAD);
        check_exact(2, ref_job(v, 4, 1'b0));
        release_out(2);

        // Backpressure: hold DONE 10 cycles, in_valid pulse must be ignored
        v = {16'h2000, 16'h0000, 16'h1000};
        e = ref_job(v, 16, 1'b0);
        start_job(0, v);
        wait_valid(0, lat);
        hx = xo[0]; hy = yo[0]; hz = zo[0];
        for (int c = 0; c < 10; c++) begin
            iv[0] = (c == 3 || c == 4);
            xi[0] = 16'h1234;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid_held", int'(ov[0]), 1);
            chk("bp_x_out_held", int'(xo[0]), int'(hx));
            chk("bp_z_out_held", int'(zo[0]), int'(hz));
            chk("bp_in_ready_low", int'(ir[0]), 0);
        end
        iv[0] = 1'b0;
        check_exact(0, e);
        release_out(0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_pulse_not_accepted", int'(bsy[0]), 0);
        end

        // out_ready already high when DONE is entered: exactly one valid cycle
        v = {16'h0C00, 16'h0800, 16'hF000};
        ordy[0] = 1'b1;
        start_job(0, v);
        wait_valid(0, lat);
        chk("rdy_high_latency", lat, exp_lat(0));
        check_exact(0, ref_job(v, 16, 1'b0));
        n = 0;
        while (ov[0] && n < 5) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rdy_high_valid_cycles", n, 1);
        ordy[0] = 1'b0;

        // Reset at iteration 5 abandons the job
        v = {16'h2000, 16'h0000, 16'h2000};
        start_job(0, v);
        n = 0;
        while (si[0] != 5'd5 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reached_iter5", int'(si[0]), 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_out_valid", int'(ov[0]), 0);
        chk("midrst_in_ready", int'(ir[0]), 1);
        chk("midrst_stg_i", int'(si[0]), 0);
        v = {16'h2000, 16'h0000, 16'h0000};
        start_job(0, v);
        wait_valid(0, lat);
        chk("postrst_latency", lat, exp_lat(0));
        check_exact(0, ref_job(v, 16, 1'b0));
        release_out(0);

        // Randomized jobs against the reference model
        for (int r = 0; r < 24; r++) begin
            u = $urandom_range(0, 2);
            v.x = 16'($urandom_range(0, 'h6000) - 'h3000);
            v.y = 16'($urandom_range(0, 'h6000) - 'h3000);
            v.z = VECS[u] ? 16'h0000 : 16'($urandom_range(0, 'hFFFF));
            e = ref_job(v, ITERS[u], VECS[u]);
            start_job(u, v);
            wait_valid(u, lat);
            chk("rand_latency", lat, exp_lat(u));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                chk("rand_valid_held", int'(ov[u]), 1);
            end
            check_exact(u, e);
            release_out(u);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
